mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM pipeline stage control: data-memory handshake, stall, timeout and MEM/WB register.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        Branch,
  input  logic        BranchGeq,
  input  logic        Zero,
  input  logic        GreaterThanEqualZero,
  input  logic [63:0] Address,
  input  logic [63:0] ALUResult,
  input  logic [63:0] WriteData,
  input  logic [4:0]  WriteReg,
  output logic        maintain,
  output logic        PCSrc,
  output logic [63:0] BranchTarget,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] OutReadData,
  output logic [63:0] OutALUResult,
  output logic [4:0]  OutWriteReg,
  output logic        OutRegWrite,
  output logic        OutMemtoReg,
  output logic        mem_fault,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] waitCnt;
  logic       access;
  logic       misalignedAcc;
  logic       readHit;
  logic       lastWait;

  assign access       = MemRead | MemWrite;
  assign PCSrc        = (Branch & Zero) | (BranchGeq & GreaterThanEqualZero);
  assign BranchTarget = Address;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalignedAcc = access & (ALUResult[2:0] != 3'b000);
`else
  assign misalignedAcc = 1'b0;
`endif

  assign mem_req   = !reset && access && !misalignedAcc && (state != FAULT);
  assign mem_we    = MemWrite;
  assign mem_addr  = ALUResult;
  assign mem_wdata = WriteData;
  assign maintain  = mem_req & !mem_ack;

  // A simultaneous read+write is a write, so no read data is captured.
  assign readHit  = MemRead & !MemWrite & mem_req & mem_ack;
  assign lastWait = ({1'b0, waitCnt} + 9'd1) >= {1'b0, MaxWait};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      waitCnt      <= 8'd0;
      OutReadData  <= 64'd0;
      OutALUResult <= 64'd0;
      OutWriteReg  <= 5'd0;
      OutRegWrite  <= 1'b0;
      OutMemtoReg  <= 1'b0;
      mem_fault    <= 1'b0;
      misalign     <= 1'b0;
    end else begin
      misalign <= 1'b0;

      case (state)
        IDLE: begin
          if (mem_req && !mem_ack) begin
            state   <= WAIT;
            waitCnt <= 8'd0;
          end
        end
        WAIT: begin
          if (mem_ack || !mem_req) begin
            state <= IDLE;
          end else begin
            if (waitCnt != MaxWait) waitCnt <= waitCnt + 8'd1;
            if (lastWait) state <= FAULT;
          end
        end
        FAULT: begin
          state     <= IDLE;
          mem_fault <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Abandoned or trapped accesses still retire, but never write back.
      if (state == FAULT || (!maintain && misalignedAcc)) begin
        OutALUResult <= ALUResult;
        OutWriteReg  <= WriteReg;
        OutMemtoReg  <= MemtoReg;
        OutRegWrite  <= 1'b0;
        OutReadData  <= 64'd0;
        if (state != FAULT) misalign <= 1'b1;
      end else if (maintain) begin
        OutRegWrite <= 1'b0;
      end else begin
        OutALUResult <= ALUResult;
        OutWriteReg  <= WriteReg;
        OutMemtoReg  <= MemtoReg;
        OutRegWrite  <= RegWrite;
        OutReadData  <= readHit ? mem_rdata : 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed table-driven bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic        Branch, BranchGeq, Zero, GreaterThanEqualZero;
  logic [63:0] Address, ALUResult, WriteData;
  logic [4:0]  WriteReg;
  logic        maintain, PCSrc;
  logic [63:0] BranchTarget;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] OutReadData, OutALUResult;
  logic [4:0]  OutWriteReg;
  logic        OutRegWrite, OutMemtoReg;
  logic        mem_fault, misalign;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Branch(Branch), .BranchGeq(BranchGeq), .Zero(Zero), .GreaterThanEqualZero(GreaterThanEqualZero),
    .Address(Address), .ALUResult(ALUResult), .WriteData(WriteData), .WriteReg(WriteReg),
    .maintain(maintain), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .OutReadData(OutReadData), .OutALUResult(OutALUResult), .OutWriteReg(OutWriteReg),
    .OutRegWrite(OutRegWrite), .OutMemtoReg(OutMemtoReg),
    .mem_fault(mem_fault), .misalign(misalign)
  );

  typedef struct {
    logic        rd, wr, m2r, rw, br, bgeq, z, gez;
    logic [63:0] addr, alu, wdata, rdata;
    logic [4:0]  wreg;
    logic        ack;
    logic        expPc, expReq, expWe, expMaint, expRw;
    logic [63:0] expRd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic nop();
    MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
    Branch = 0; BranchGeq = 0; Zero = 0; GreaterThanEqualZero = 0;
    Address = 0; ALUResult = 0; WriteData = 0; WriteReg = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic load(input logic [63:0] a, input logic ack, input logic [63:0] rdat);
    nop();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; ALUResult = a; WriteReg = 5'd9;
    mem_ack = ack; mem_rdata = rdat;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Counts stalled cycles of a held load that is never acknowledged.
  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!maintain) break;
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{0,0,0,0,1,0,1,0, 64'h100, 64'h10, 64'h0,    64'h0,    5'd1, 0, 1,0,0,0,0, 64'h0};
    vecs[1] = '{0,0,0,1,0,1,0,0, 64'h200, 64'h20, 64'h0,    64'h0,    5'd2, 0, 0,0,0,0,1, 64'h0};
    vecs[2] = '{0,0,0,1,0,1,0,1, 64'h300, 64'h28, 64'h0,    64'h0,    5'd3, 0, 1,0,0,0,1, 64'h0};
    vecs[3] = '{0,0,0,0,1,0,0,1, 64'h400, 64'h30, 64'h0,    64'h0,    5'd4, 0, 0,0,0,0,0, 64'h0};
    vecs[4] = '{0,1,0,0,0,0,0,0, 64'h0,   64'h80, 64'hCAFE, 64'h0,    5'd0, 1, 0,1,1,0,0, 64'h0};
    vecs[5] = '{1,0,1,1,0,0,0,0, 64'h0,   64'h88, 64'h0,    64'h1234, 5'd5, 1, 0,1,0,0,1, 64'h1234};
    vecs[6] = '{0,0,0,1,0,0,0,0, 64'h0,   64'h99, 64'h0,    64'h5555, 5'd6, 1, 0,0,0,0,1, 64'h0};
    vecs[7] = '{1,1,0,1,0,0,0,0, 64'h0,   64'h90, 64'hBEEF, 64'h7777, 5'd7, 1, 0,1,1,0,1, 64'h0};
    vecs[8] = '{0,1,0,1,0,0,0,0, 64'h0,   64'hA0, 64'h1111, 64'h0,    5'd8, 1, 0,1,1,0,1, 64'h0};

    // Reset with a pending load: request and stall must be suppressed.
    reset = 1;
    load(64'h40, 0, 0);
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_maintain", maintain, 0);
    chk("rst_out_rw", OutRegWrite, 0);
    chk("rst_out_alu", OutALUResult, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_misalign", misalign, 0);
    nop();
    reset = 0;
    tick();

    for (int i = 0; i < 9; i++) begin
      MemRead = vecs[i].rd; MemWrite = vecs[i].wr; MemtoReg = vecs[i].m2r; RegWrite = vecs[i].rw;
      Branch = vecs[i].br; BranchGeq = vecs[i].bgeq; Zero = vecs[i].z; GreaterThanEqualZero = vecs[i].gez;
      Address = vecs[i].addr; ALUResult = vecs[i].alu; WriteData = vecs[i].wdata;
      mem_rdata = vecs[i].rdata; WriteReg = vecs[i].wreg; mem_ack = vecs[i].ack;
      #1;
      chk($sformatf("v%0d_pcsrc", i), PCSrc, vecs[i].expPc);
      chk($sformatf("v%0d_target", i), BranchTarget, vecs[i].addr);
      chk($sformatf("v%0d_req", i), mem_req, vecs[i].expReq);
      chk($sformatf("v%0d_we", i), mem_we, vecs[i].expWe);
      chk($sformatf("v%0d_maint", i), maintain, vecs[i].expMaint);
      chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].alu);
      chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
      tick();
      chk($sformatf("v%0d_out_rd", i), OutReadData, vecs[i].expRd);
      chk($sformatf("v%0d_out_alu", i), OutALUResult, vecs[i].alu);
      chk($sformatf("v%0d_out_rw", i), OutRegWrite, vecs[i].expRw);
      chk($sformatf("v%0d_out_wreg", i), {59'd0, OutWriteReg}, {59'd0, vecs[i].wreg});
      chk($sformatf("v%0d_out_m2r", i), OutMemtoReg, vecs[i].m2r);
    end

    // Load acknowledged two cycles after the request.
    load(64'h40, 0, 0); #1;
    chk("ld2_maint_c1", maintain, 1);
    tick();
    chk("ld2_bubble", OutRegWrite, 0);
    chk("ld2_maint_c2", maintain, 1);
    tick();
    mem_ack = 1; mem_rdata = 64'hDEADBEEF; #1;
    chk("ld2_maint_c3", maintain, 0);
    chk("ld2_req_c3", mem_req, 1);
    tick();
    chk("ld2_out_rd", OutReadData, 64'hDEADBEEF);
    chk("ld2_out_rw", OutRegWrite, 1);
    nop(); tick();

    // Load never acknowledged: MAX_WAIT+1 stall cycles then a FAULT cycle.
    load(64'h48, 0, 0); #1;
    count_stall(n);
    chk("to_stall_cycles", 64'(n), 64'(MW + 1));
    chk("to_fault_req", mem_req, 0);
    chk("to_fault_maint", maintain, 0);
    tick();
    chk("to_fault_flag", mem_fault, 1);
    chk("to_out_rw", OutRegWrite, 0);
    chk("to_out_rd", OutReadData, 0);
    nop(); tick();
    chk("to_fault_sticky", mem_fault, 1);
    load(64'h50, 1, 64'h77); #1;
    chk("to_idle_req", mem_req, 1);
    chk("to_idle_maint", maintain, 0);
    tick();
    chk("to_idle_rd", OutReadData, 64'h77);

    // Reset in the second WAIT cycle.
    load(64'h58, 0, 0); #1;
    tick(); tick();
    reset = 1; #1;
    chk("rw_req", mem_req, 0);
    chk("rw_maint", maintain, 0);
    tick();
    chk("rw_out_rd", OutReadData, 0);
    chk("rw_out_alu", OutALUResult, 0);
    chk("rw_out_rw", OutRegWrite, 0);
    chk("rw_out_m2r", OutMemtoReg, 0);
    chk("rw_fault", mem_fault, 0);
    reset = 0;
    nop(); tick();
    load(64'h60, 0, 0); #1;
    count_stall(n);
    chk("rw_idle_stall", 64'(n), 64'(MW + 1));
    nop(); tick(); tick();

`ifdef MEM_ALIGN_CHECK_EN
    load(64'h43, 0, 0); #1;
    chk("mis_req", mem_req, 0);
    chk("mis_maint", maintain, 0);
    tick();
    chk("mis_pulse", misalign, 1);
    chk("mis_out_rw", OutRegWrite, 0);
    chk("mis_out_rd", OutReadData, 0);
    nop(); tick();
    chk("mis_pulse_end", misalign, 0);
`else
    load(64'h43, 1, 64'h5); #1;
    chk("mis_req", mem_req, 1);
    chk("mis_addr", mem_addr, 64'h43);
    tick();
    chk("mis_pulse", misalign, 0);
    chk("mis_out_rd", OutReadData, 64'h5);
    chk("mis_out_rw", OutRegWrite, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
